// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle mul/div in EX and data-memory wait, plus a stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_uses_rt,
  input  logic        branch_taken,
  input  logic        ex_muldiv,
  input  logic        ex_is_div,
  input  logic        mem_stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        ex_mem_hold,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        muldiv_done,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ack, ack_next;
  logic             load_use;

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack   <= ack_next;
    end
  end

  // Highest-priority event wins; the entry cycle counts as the first of LAT stall cycles.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ack_next     = ack;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    muldiv_done  = 1'b0;
    md_busy      = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      md_busy = (state == MD_BUSY);
      if (mem_stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_hold   = 1'b1;
        ex_mem_hold  = 1'b1;
        mem_wb_flush = 1'b1;
      end else if ((state == MD_BUSY) || (ex_muldiv && !ack)) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
        if (state == RUN) begin
          cnt_next   = ex_is_div ? DIV_INIT : MUL_INIT;
          state_next = MD_BUSY;
        end else if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = RUN;
          ack_next   = 1'b1;
        end
      end else if (ex_muldiv && ack) begin
        muldiv_done = 1'b1;
        ack_next    = 1'b0;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed table-driven bench for pipeline_hazard_controller plus
// hand-written mul/div, memory-wait and mid-operation reset sequences.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic        id_uses_rt, branch_taken, ex_muldiv, ex_is_div, mem_stall;
  logic        pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush;
  logic        ex_mem_hold, ex_mem_flush, mem_wb_flush, muldiv_done, md_busy;
  logic [31:0] stall_cycles;
  logic [9:0]  act;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_stall = 0;

  // Output order: pc_write if_id_write if_id_flush id_ex_hold id_ex_flush
  //               ex_mem_hold ex_mem_flush mem_wb_flush muldiv_done md_busy
  localparam logic [9:0] NORM = 10'b1100000000;
  localparam logic [9:0] LU   = 10'b0000100000;
  localparam logic [9:0] BR   = 10'b1110100000;
  localparam logic [9:0] MS   = 10'b0001010100;
  localparam logic [9:0] MD   = 10'b0001001000;
  localparam logic [9:0] DONE = 10'b1100000010;
  localparam logic [9:0] ZERO = 10'b0000000000;

  typedef struct {
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       mstall;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  pipeline_hazard_controller #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
    .branch_taken(branch_taken), .ex_muldiv(ex_muldiv), .ex_is_div(ex_is_div),
    .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .muldiv_done(muldiv_done), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  assign act = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush,
                ex_mem_hold, ex_mem_flush, mem_wb_flush, muldiv_done, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic br,
                        input logic ms, input logic [9:0] exp, input string name);
    vec_t v;
    v.mem_read = mr; v.ex_rt = ert; v.rs = rs; v.rt = rt; v.uses_rt = ur;
    v.br = br; v.mstall = ms; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    id_ex_mem_read = v.mem_read;
    id_ex_rt       = v.ex_rt;
    if_id_rs       = v.rs;
    if_id_rt       = v.rt;
    id_uses_rt     = v.uses_rt;
    branch_taken   = v.br;
    mem_stall      = v.mstall;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic checkOutput(input string name, input logic [9:0] exp);
    #1;
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp);
    end
    n_vec++;
    if (stall_cycles !== 32'(exp_stall)) begin
      n_fail++;
      $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp_stall);
    end
    if (!reset && !exp[9]) exp_stall++;
    @(negedge clk);
  endtask

  task automatic clearInputs();
    id_ex_mem_read = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    id_uses_rt = 0; branch_taken = 0; ex_muldiv = 0; ex_is_div = 0; mem_stall = 0;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();

    addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NORM, "idle");
    addVec(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, LU,   "T1 load-use rs");
    addVec(0, 5'd8, 5'd8, 5'd0, 0, 0, 0, NORM, "T1 load advanced");
    addVec(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, NORM, "T2 rt zero");
    addVec(1, 5'd8, 5'd9, 5'd8, 0, 0, 0, NORM, "T2 rt not used");
    addVec(1, 5'd8, 5'd9, 5'd8, 1, 0, 0, LU,   "load-use rt");
    addVec(1, 5'd8, 5'd8, 5'd0, 0, 1, 0, BR,   "T3 branch over load-use");
    addVec(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, BR,   "branch alone");
    addVec(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, MS,   "mem stall");
    addVec(1, 5'd8, 5'd8, 5'd0, 0, 1, 1, MS,   "mem stall over branch");
    addVec(1, 5'd8, 5'd3, 5'd4, 1, 0, 0, NORM, "load no match");

    #2;
    checkOutput("reset state", ZERO);
    reset = 1'b0;

    foreach (vq[i]) begin
      applyStimulus(vq[i]);
      checkOutput(vq[i].name, vq[i].exp);
    end
    clearInputs();

    // T4: multiply, four stall cycles then a single done pulse
    ex_muldiv = 1'b1; ex_is_div = 1'b0;
    checkOutput("T4 mul entry", MD);
    for (int c = 0; c < 3; c++) checkOutput("T4 mul busy", MD | 10'b1);
    checkOutput("T4 mul done", DONE);
    ex_muldiv = 1'b0;
    checkOutput("T4 after done", NORM);

    // T5: divide with a five-cycle memory wait inside the busy window
    ex_muldiv = 1'b1; ex_is_div = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      mem_stall = (c >= 6 && c <= 10);
      checkOutput(mem_stall ? "T5 div mem wait" : "T5 div busy",
                  (mem_stall ? MS : MD) | ((c == 1) ? 10'b0 : 10'b1));
    end
    mem_stall = 1'b0;
    checkOutput("T5 div done", DONE);
    ex_muldiv = 1'b0;
    checkOutput("T5 after done", NORM);

    // T6: reset during the tenth busy cycle of a divide
    ex_muldiv = 1'b1; ex_is_div = 1'b1;
    checkOutput("T6 div entry", MD);
    for (int c = 0; c < 9; c++) checkOutput("T6 div busy", MD | 10'b1);
    reset = 1'b1;
    ex_muldiv = 1'b0;
    exp_stall = 0;
    checkOutput("T6 reset async", ZERO);
    checkOutput("T6 reset held", ZERO);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) checkOutput("T6 after reset", NORM);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
